// File: rtl/emblem_sequencer_if.sv
// Pixel-side bundle between the VGA timing/background path, the emblem
// generator and the crest overlay sequencer.
interface emblem_sequencer_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       trigger;
  logic       abort;
  logic       em_draw;
  logic [5:0] em_rgb;
  logic [5:0] bg_rgb;
  logic       em_enable;
  logic [5:0] out_rgb;
  logic       busy;
  logic [1:0] level;

  modport master (
    output x, y, active, trigger, abort, em_draw, em_rgb, bg_rgb,
    input  em_enable, out_rgb, busy, level
  );

  modport slave (
    input  x, y, active, trigger, abort, em_draw, em_rgb, bg_rgb,
    output em_enable, out_rgb, busy, level
  );
endinterface

// File: rtl/emblem_sequencer.sv
// Crest overlay sequencer: frame-synchronous fade-in/hold/blink/fade-out
// scheduling plus brightness-ramped compositing over the background.
module emblem_sequencer #(
  parameter int unsigned FADE_STEP_FRAMES = 8,
  parameter int unsigned HOLD_FRAMES      = 180,
  parameter int unsigned BLINK_FRAMES     = 16,
  parameter int unsigned BLINK_COUNT      = 3,
  parameter int unsigned FRAME_Y          = 480
) (
  input  logic           clk,
  input  logic           rst_n,
  emblem_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FADE_IN,
    HOLD,
    BLINK,
    FADE_OUT
  } state_t;

  localparam logic [9:0] TICK_Y     = 10'(FRAME_Y);
  localparam logic [7:0] FADE_LAST  = 8'(FADE_STEP_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] TOG_END    = 8'(2 * BLINK_COUNT);

  state_t     state_q, state_d;
  logic [1:0] level_q, level_d;
  logic       visible_q, visible_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [7:0] toggles_q, toggles_d;
  logic       trig_pend_q, trig_pend_d;
  logic       abort_pend_q, abort_pend_d;
  logic [5:0] out_rgb_q, out_rgb_d;
  logic       busy_q, busy_d;

  logic tick;
  logic in_run;
  logic trig_set;
  logic abort_set;

  // Saturating per-channel subtract of (3 - level) on an RRGGBB pixel.
  function automatic logic [5:0] dim(input logic [5:0] c, input logic [1:0] lvl);
    logic [5:0] res;
    logic [1:0] sub;
    logic [1:0] ch;
    res = '0;
    sub = 2'd3 - lvl;
    for (int unsigned i = 0; i < 3; i++) begin
      ch = c[2*i +: 2];
      res[2*i +: 2] = (ch > sub) ? (ch - sub) : 2'd0;
    end
    return res;
  endfunction

  assign tick   = (bus.x == 10'd0) && (bus.y == TICK_Y);
  assign in_run = (state_q == FADE_IN) || (state_q == HOLD) || (state_q == BLINK);

  // Abort wins over a coincident trigger; requests landing on a tick cycle
  // survive that tick and are acted on at the next one.
  assign trig_set  = bus.trigger && !bus.abort && (state_q == IDLE);
  assign abort_set = bus.abort && in_run;

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    visible_d    = visible_q;
    fcnt_d       = fcnt_q;
    toggles_d    = toggles_q;
    trig_pend_d  = (trig_pend_q && !tick) || trig_set;
    abort_pend_d = (abort_pend_q && !tick) || abort_set;

    if (tick) begin
      if (abort_pend_q && in_run) begin
        state_d   = FADE_OUT;
        fcnt_d    = '0;
        visible_d = 1'b1;
        toggles_d = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            level_d   = '0;
            visible_d = 1'b1;
            if (trig_pend_q) begin
              state_d = FADE_IN;
              level_d = 2'd1;
              fcnt_d  = '0;
            end
          end
          FADE_IN: begin
            if (fcnt_q == FADE_LAST) begin
              fcnt_d = '0;
              if (level_q == 2'd3) state_d = HOLD;
              else                 level_d = level_q + 2'd1;
            end else begin
              fcnt_d = fcnt_q + 8'd1;
            end
          end
          HOLD: begin
            level_d = 2'd3;
            if (fcnt_q == HOLD_LAST) begin
              state_d = (BLINK_COUNT == 0) ? FADE_OUT : BLINK;
              fcnt_d  = '0;
            end else begin
              fcnt_d = fcnt_q + 8'd1;
            end
          end
          BLINK: begin
            if (fcnt_q == BLINK_LAST) begin
              fcnt_d = '0;
              if (toggles_q + 8'd1 == TOG_END) begin
                state_d   = FADE_OUT;
                visible_d = 1'b1;
                toggles_d = '0;
              end else begin
                visible_d = !visible_q;
                toggles_d = toggles_q + 8'd1;
              end
            end else begin
              fcnt_d = fcnt_q + 8'd1;
            end
          end
          FADE_OUT: begin
            if (fcnt_q == FADE_LAST) begin
              fcnt_d = '0;
              if (level_q == 2'd1) begin
                state_d = IDLE;
                level_d = '0;
              end else begin
                level_d = level_q - 2'd1;
              end
            end else begin
              fcnt_d = fcnt_q + 8'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    busy_d = (state_d != IDLE);

    if (!bus.active)
      out_rgb_d = '0;
    else if (bus.em_draw && (state_q != IDLE) && visible_q)
      out_rgb_d = dim(bus.em_rgb, level_q);
    else
      out_rgb_d = bus.bg_rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      level_q      <= '0;
      visible_q    <= 1'b1;
      fcnt_q       <= '0;
      toggles_q    <= '0;
      trig_pend_q  <= 1'b0;
      abort_pend_q <= 1'b0;
      out_rgb_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      visible_q    <= visible_d;
      fcnt_q       <= fcnt_d;
      toggles_q    <= toggles_d;
      trig_pend_q  <= trig_pend_d;
      abort_pend_q <= abort_pend_d;
      out_rgb_q    <= out_rgb_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.em_enable = bus.active && (state_q != IDLE) && visible_q;
  assign bus.out_rgb   = out_rgb_q;
  assign bus.busy      = busy_q;
  assign bus.level     = level_q;

endmodule

// File: tb/tb_emblem_sequencer.sv
// Directed bench for emblem_sequencer: one instance with a single blink
// cycle and one with blinking disabled, both fed identical stimulus.
module tb_emblem_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  emblem_sequencer_if b0 ();
  emblem_sequencer_if b1 ();

  assign b1.x       = b0.x;
  assign b1.y       = b0.y;
  assign b1.active  = b0.active;
  assign b1.trigger = b0.trigger;
  assign b1.abort   = b0.abort;
  assign b1.em_draw = b0.em_draw;
  assign b1.em_rgb  = b0.em_rgb;
  assign b1.bg_rgb  = b0.bg_rgb;

  emblem_sequencer #(
    .FADE_STEP_FRAMES(2), .HOLD_FRAMES(4), .BLINK_FRAMES(2),
    .BLINK_COUNT(1), .FRAME_Y(480)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  emblem_sequencer #(
    .FADE_STEP_FRAMES(2), .HOLD_FRAMES(4), .BLINK_FRAMES(2),
    .BLINK_COUNT(0), .FRAME_Y(480)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic do_tick();
    @(negedge clk);
    b0.x = 10'd0;
    b0.y = 10'd480;
    @(negedge clk);
    b0.x = 10'd1;
    b0.y = 10'd0;
  endtask

  task automatic pulse(input logic trig, input logic abt);
    @(negedge clk);
    b0.trigger = trig;
    b0.abort   = abt;
    @(negedge clk);
    b0.trigger = 1'b0;
    b0.abort   = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    b0.x       = 10'd1;
    b0.y       = 10'd0;
    b0.active  = 1'b1;
    b0.trigger = 1'b0;
    b0.abort   = 1'b0;
    b0.em_draw = 1'b1;
    b0.em_rgb  = 6'h3F;
    b0.bg_rgb  = 6'b000111;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (b0.out_rgb !== 6'd0) $display("FAIL reset_out_rgb: got %b expected %b", b0.out_rgb, 6'd0);
    else pass_cnt++;
    total_cnt++;
    if (b0.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", b0.busy);
    else pass_cnt++;
    total_cnt++;
    if (b0.level !== 2'd0) $display("FAIL reset_level: got %0d expected 0", b0.level);
    else pass_cnt++;
    total_cnt++;
    if (b0.em_enable !== 1'b0) $display("FAIL reset_em_enable: got %b expected 0", b0.em_enable);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (b0.out_rgb !== 6'b000111) $display("FAIL post_reset_bg: got %b expected %b", b0.out_rgb, 6'b000111);
    else pass_cnt++;
  endtask

  task automatic test_full_sequence();
    int lv0 [21] = '{1,1,2,2,3,3,3,3,3,3, 3,3,3,3,3,3,2,2,1,1, 0};
    int en0 [21] = '{1,1,1,1,1,1,1,1,1,1, 1,1,0,0,1,1,1,1,1,1, 0};
    int bz0 [21] = '{1,1,1,1,1,1,1,1,1,1, 1,1,1,1,1,1,1,1,1,1, 0};
    int lv1 [21] = '{1,1,2,2,3,3,3,3,3,3, 3,3,2,2,1,1,0,0,0,0, 0};
    int bz1 [21] = '{1,1,1,1,1,1,1,1,1,1, 1,1,1,1,1,1,0,0,0,0, 0};
    reset_dut();
    b0.active = 1'b1;
    pulse(1'b1, 1'b0);
    total_cnt++;
    if (b0.busy !== 1'b0) $display("FAIL busy_before_tick: got %b expected 0", b0.busy);
    else pass_cnt++;
    for (int t = 0; t < 21; t++) begin
      do_tick();
      total_cnt++;
      if (b0.level !== 2'(lv0[t])) $display("FAIL seq_level tick %0d: got %0d expected %0d", t+1, b0.level, lv0[t]);
      else pass_cnt++;
      total_cnt++;
      if (b0.busy !== 1'(bz0[t])) $display("FAIL seq_busy tick %0d: got %b expected %0d", t+1, b0.busy, bz0[t]);
      else pass_cnt++;
      total_cnt++;
      if (b0.em_enable !== 1'(en0[t])) $display("FAIL seq_visible tick %0d: got %b expected %0d", t+1, b0.em_enable, en0[t]);
      else pass_cnt++;
      total_cnt++;
      if (b1.level !== 2'(lv1[t])) $display("FAIL noblink_level tick %0d: got %0d expected %0d", t+1, b1.level, lv1[t]);
      else pass_cnt++;
      total_cnt++;
      if (b1.busy !== 1'(bz1[t])) $display("FAIL noblink_busy tick %0d: got %b expected %0d", t+1, b1.busy, bz1[t]);
      else pass_cnt++;
    end
  endtask

  task automatic test_trigger_on_tick();
    reset_dut();
    @(negedge clk);
    b0.trigger = 1'b1;
    b0.x       = 10'd0;
    b0.y       = 10'd480;
    @(negedge clk);
    b0.trigger = 1'b0;
    b0.x       = 10'd1;
    b0.y       = 10'd0;
    total_cnt++;
    if (b0.busy !== 1'b0) $display("FAIL trig_same_tick_busy: got %b expected 0", b0.busy);
    else pass_cnt++;
    do_tick();
    total_cnt++;
    if (b0.busy !== 1'b1 || b0.level !== 2'd1)
      $display("FAIL trig_next_tick: got busy=%b level=%0d expected busy=1 level=1", b0.busy, b0.level);
    else pass_cnt++;
  endtask

  task automatic test_dimming();
    int lv_ab [4] = '{2,2,1,1};
    reset_dut();
    b0.active  = 1'b1;
    b0.em_draw = 1'b1;
    b0.em_rgb  = 6'b110110;
    b0.bg_rgb  = 6'b000111;
    pulse(1'b1, 1'b0);
    do_tick();
    @(negedge clk);
    total_cnt++;
    if (b0.out_rgb !== 6'b010000) $display("FAIL dim_level1: got %b expected %b", b0.out_rgb, 6'b010000);
    else pass_cnt++;
    do_tick();
    do_tick();
    @(negedge clk);
    total_cnt++;
    if (b0.out_rgb !== 6'b100001) $display("FAIL dim_level2: got %b expected %b", b0.out_rgb, 6'b100001);
    else pass_cnt++;
    b0.em_draw = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (b0.out_rgb !== 6'b000111) $display("FAIL dim_no_draw_bg: got %b expected %b", b0.out_rgb, 6'b000111);
    else pass_cnt++;
    // Abort during FADE_IN at level 2: fade out from level 2
    pulse(1'b0, 1'b1);
    for (int t = 0; t < 4; t++) begin
      do_tick();
      total_cnt++;
      if (b0.level !== 2'(lv_ab[t]) || b0.busy !== 1'b1)
        $display("FAIL abort_fadein tick %0d: got level=%0d busy=%b expected level=%0d busy=1", t, b0.level, b0.busy, lv_ab[t]);
      else pass_cnt++;
    end
    do_tick();
    total_cnt++;
    if (b0.busy !== 1'b0) $display("FAIL abort_fadein_idle: got %b expected 0", b0.busy);
    else pass_cnt++;
  endtask

  task automatic test_abort_hold();
    int lv_fo [6] = '{3,3,2,2,1,1};
    reset_dut();
    b0.active = 1'b1;
    pulse(1'b1, 1'b0);
    repeat (8) do_tick();
    pulse(1'b0, 1'b1);
    for (int t = 0; t < 6; t++) begin
      if (t == 3) pulse(1'b0, 1'b1);
      do_tick();
      total_cnt++;
      if (b0.level !== 2'(lv_fo[t]) || b0.busy !== 1'b1)
        $display("FAIL abort_hold tick %0d: got level=%0d busy=%b expected level=%0d busy=1", t, b0.level, b0.busy, lv_fo[t]);
      else pass_cnt++;
    end
    do_tick();
    total_cnt++;
    if (b0.busy !== 1'b0 || b0.level !== 2'd0)
      $display("FAIL abort_hold_idle: got busy=%b level=%0d expected busy=0 level=0", b0.busy, b0.level);
    else pass_cnt++;
    pulse(1'b0, 1'b1);
    do_tick();
    do_tick();
    total_cnt++;
    if (b0.busy !== 1'b0) $display("FAIL abort_in_idle: got busy=%b expected 0", b0.busy);
    else pass_cnt++;
  endtask

  task automatic test_requests();
    int lv_fi [4] = '{1,1,2,2};
    reset_dut();
    pulse(1'b1, 1'b1);
    do_tick();
    do_tick();
    total_cnt++;
    if (b0.busy !== 1'b0) $display("FAIL trig_abort_idle: got busy=%b expected 0", b0.busy);
    else pass_cnt++;
    pulse(1'b1, 1'b0);
    for (int t = 0; t < 4; t++) begin
      if (t == 1) pulse(1'b1, 1'b0);
      do_tick();
      total_cnt++;
      if (b0.level !== 2'(lv_fi[t]))
        $display("FAIL trig_in_fadein tick %0d: got level=%0d expected %0d", t, b0.level, lv_fi[t]);
      else pass_cnt++;
    end
  endtask

  task automatic test_blink_gating();
    reset_dut();
    b0.active  = 1'b1;
    b0.em_draw = 1'b1;
    b0.em_rgb  = 6'b101101;
    b0.bg_rgb  = 6'b010010;
    pulse(1'b1, 1'b0);
    repeat (11) do_tick();
    total_cnt++;
    if (b0.em_enable !== 1'b1) $display("FAIL blink_on_enable: got %b expected 1", b0.em_enable);
    else pass_cnt++;
    b0.active = 1'b0;
    #1;
    total_cnt++;
    if (b0.em_enable !== 1'b0) $display("FAIL blink_inactive_enable: got %b expected 0", b0.em_enable);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (b0.out_rgb !== 6'd0) $display("FAIL blink_inactive_rgb: got %b expected %b", b0.out_rgb, 6'd0);
    else pass_cnt++;
    b0.active = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (b0.out_rgb !== 6'b101101) $display("FAIL blink_full_rgb: got %b expected %b", b0.out_rgb, 6'b101101);
    else pass_cnt++;
    do_tick();
    do_tick();
    @(negedge clk);
    total_cnt++;
    if (b0.em_enable !== 1'b0 || b0.out_rgb !== 6'b010010)
      $display("FAIL blink_off: got en=%b rgb=%b expected en=0 rgb=%b", b0.em_enable, b0.out_rgb, 6'b010010);
    else pass_cnt++;
    pulse(1'b0, 1'b1);
    do_tick();
    total_cnt++;
    if (b0.em_enable !== 1'b1 || b0.level !== 2'd3)
      $display("FAIL blink_abort: got en=%b level=%0d expected en=1 level=3", b0.em_enable, b0.level);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (b0.busy !== 1'b0 || b0.level !== 2'd0 || b0.out_rgb !== 6'd0 || b0.em_enable !== 1'b0)
      $display("FAIL async_reset: got busy=%b level=%0d rgb=%b en=%b expected 0 0 000000 0",
               b0.busy, b0.level, b0.out_rgb, b0.em_enable);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    do_tick();
    do_tick();
    total_cnt++;
    if (b0.busy !== 1'b0) $display("FAIL reset_drops_pending: got busy=%b expected 0", b0.busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_trigger_on_tick();
    test_dimming();
    test_abort_hold();
    test_requests();
    test_blink_gating();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
